// File: rtl/grid_loader.sv
// grid_loader: parses an ASCII '@'/'.' puzzle stream into a WIDTH x DEPTH bit grid.
// Define GRID_LOADER_PAPER_COUNT_EN to enable the paper_count counter.
module grid_loader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [7:0]                           in_data,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    output logic                                 in_ready,
    output logic [WIDTH*DEPTH-1:0]               grid_flat,
    output logic                                 grid_valid,
    input  logic                                 grid_ack,
    output logic [$clog2(DEPTH+1)-1:0]           rows_loaded,
    output logic [$clog2(WIDTH*DEPTH+1)-1:0]     paper_count,
    output logic                                 err
);

    localparam int N  = WIDTH * DEPTH;
    localparam int RW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(N + 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(DEPTH - 1);

    typedef enum logic [1:0] {LOAD, DONE, ERR} state_t;

    state_t        state, state_n;
    logic [N-1:0]  grid, grid_n;
    logic [RW-1:0] row, row_n;
    logic [CW-1:0] col, col_n;
    logic [PW-1:0] cell_idx;
    logic          is_at, is_dot, is_lf, is_cr, is_cell, illegal;

    assign is_at    = in_data == 8'h40;
    assign is_dot   = in_data == 8'h2E;
    assign is_lf    = in_data == 8'h0A;
    assign is_cr    = in_data == 8'h0D;
    assign is_cell  = is_at || is_dot;
    assign illegal  = !(is_cell || is_lf || is_cr) ||
                      (is_cell && col == COL_MAX);
    assign cell_idx = PW'(row) * PW'(WIDTH) + PW'(col);

    always_comb begin
        state_n    = state;
        grid_n     = grid;
        row_n      = row;
        col_n      = col;
        in_ready   = 1'b0;
        grid_valid = 1'b0;
        err        = 1'b0;
        unique case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (illegal) begin
                        state_n = ERR;
                    end else begin
                        if (is_cell) begin
                            grid_n = grid | (N'(is_at) << cell_idx);
                            col_n  = col + CW'(1);
                        end
                        if (is_lf && col != '0) begin
                            row_n = row + RW'(1);
                            col_n = '0;
                            if (row == ROW_LAST) state_n = DONE;
                        end
                        // A trailing partial row still counts as a completed row
                        if (in_last) begin
                            state_n = DONE;
                            if (col_n != '0) begin
                                row_n = row + RW'(1);
                                col_n = '0;
                            end
                        end
                    end
                end
            end
            DONE: begin
                grid_valid = 1'b1;
                if (grid_ack) begin
                    state_n = LOAD;
                    grid_n  = '0;
                    row_n   = '0;
                    col_n   = '0;
                end
            end
            ERR: begin
                in_ready = 1'b1;
                err      = 1'b1;
            end
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            grid  <= '0;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_n;
            grid  <= grid_n;
            row   <= row_n;
            col   <= col_n;
        end
    end

    assign grid_flat   = grid;
    assign rows_loaded = row;

`ifdef GRID_LOADER_PAPER_COUNT_EN
    logic [PW-1:0] paper;
    logic          paper_inc, paper_clr;

    assign paper_inc = state == LOAD && in_valid && is_at && !illegal;
    assign paper_clr = state == DONE && grid_ack;

    always_ff @(posedge clk) begin
        if (reset || paper_clr) begin
            paper <= '0;
        end else if (paper_inc && paper != PW'(N)) begin
            paper <= paper + PW'(1);
        end
    end

    assign paper_count = paper;
`else
    assign paper_count = '0;
`endif

endmodule

// File: tb/tb_grid_loader.sv
// tb_grid_loader: random and directed streams checked against a text-level
// grid parsing model.
module tb_grid_loader;

    localparam int W = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        grid_ack = 1'b0;
    logic        in_ready;
    logic [15:0] grid_flat;
    logic        grid_valid;
    logic [2:0]  rows_loaded;
    logic [4:0]  paper_count;
    logic        err;

    grid_loader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .grid_flat(grid_flat),
        .grid_valid(grid_valid),
        .grid_ack(grid_ack),
        .rows_loaded(rows_loaded),
        .paper_count(paper_count),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  stim[$];
    bit          stim_last;
    logic [15:0] m_grid;
    int          m_rows, m_paper, m_used;
    bit          m_err, m_done;

    function automatic int exp_pc(int p);
`ifdef GRID_LOADER_PAPER_COUNT_EN
        return p;
`else
        return 0;
`endif
    endfunction

    task automatic set_stim(input string s, input bit last);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
        stim_last = last;
    endtask

    // Walks the text like a reader would: cursor (r,c), stop at DEPTH rows
    task automatic model_run();
        int r = 0;
        int c = 0;
        logic [7:0] b;
        bit lst;
        m_grid = '0; m_paper = 0; m_err = 0; m_done = 0; m_used = 0;
        foreach (stim[i]) begin
            if (m_done) break;
            m_used++;
            if (m_err) continue;
            b = stim[i];
            lst = stim_last && (i == stim.size() - 1);
            if (b == 8'h0D) begin
            end else if (b == 8'h40 || b == 8'h2E) begin
                if (c == W) m_err = 1;
                else begin
                    if (b == 8'h40) begin
                        m_grid[r*W+c] = 1'b1;
                        m_paper++;
                    end
                    c++;
                end
            end else if (b == 8'h0A) begin
                if (c > 0) begin
                    r++; c = 0;
                    if (r == D) m_done = 1;
                end
            end else begin
                m_err = 1;
            end
            if (lst && !m_err) begin
                if (c > 0) r++;
                c = 0;
                m_done = 1;
            end
        end
        m_rows = r;
    endtask

    task automatic run_stream(input string name);
        model_run();
        for (int i = 0; i < m_used; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1 || grid_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL %s byte%0d: in_ready=%b grid_valid=%b, need 1/0",
                         name, i, in_ready, grid_valid);
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            in_last  = stim_last && (i == stim.size() - 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (grid_valid !== m_done || err !== m_err || in_ready !== !m_done) begin
            n_bad++;
            $display("FAIL %s status: gv=%b err=%b rdy=%b, need %b/%b/%b",
                     name, grid_valid, err, in_ready, m_done, m_err, !m_done);
        end
        if (m_done) begin
            n_cmp++;
            if (grid_flat !== m_grid || rows_loaded !== 3'(m_rows) ||
                paper_count !== 5'(exp_pc(m_paper))) begin
                n_bad++;
                $display("FAIL %s grid: %h rows=%0d pc=%0d, need %h rows=%0d pc=%0d",
                         name, grid_flat, rows_loaded, paper_count,
                         m_grid, m_rows, exp_pc(m_paper));
            end
        end
    endtask

    task automatic ack_check(input string name);
        @(negedge clk);
        grid_ack = 1'b1;
        @(posedge clk);
        #1 grid_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (grid_valid !== 1'b0 || grid_flat !== 16'h0 || in_ready !== 1'b1 ||
            rows_loaded !== 3'd0 || paper_count !== 5'd0) begin
            n_bad++;
            $display("FAIL %s ack: gv=%b grid=%h rdy=%b rows=%0d pc=%0d, need 0/0/1/0/0",
                     name, grid_valid, grid_flat, in_ready, rows_loaded, paper_count);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (grid_flat !== 16'h0 || rows_loaded !== 3'd0 || paper_count !== 5'd0 ||
            err !== 1'b0 || grid_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s idle: grid=%h rows=%0d pc=%0d err=%b gv=%b rdy=%b, need zeros rdy=1",
                     name, grid_flat, rows_loaded, paper_count, err, grid_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("reset");
    endtask

    task automatic test_example();
        set_stim("@@.@\n.@@.\n@...\n..@@\n", 1'b0);
        run_stream("example");
        n_cmp++;
        if (grid_flat !== 16'hC16B || rows_loaded !== 3'd4 ||
            paper_count !== 5'(exp_pc(8)) || grid_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL example const: grid=%h rows=%0d pc=%0d gv=%b rdy=%b, need c16b/4/%0d/1/0",
                     grid_flat, rows_loaded, paper_count, grid_valid, in_ready, exp_pc(8));
        end
        ack_check("example");
    endtask

    task automatic test_last_partial();
        set_stim("@.\n@@@@", 1'b1);
        run_stream("last_partial");
        n_cmp++;
        if (grid_flat !== 16'h00F1 || rows_loaded !== 3'd2 ||
            paper_count !== 5'(exp_pc(5))) begin
            n_bad++;
            $display("FAIL last_partial const: grid=%h rows=%0d pc=%0d, need 00f1/2/%0d",
                     grid_flat, rows_loaded, paper_count, exp_pc(5));
        end
        ack_check("last_partial");
    endtask

    task automatic test_overflow();
        set_stim("@@@@@", 1'b0);
        run_stream("overflow");
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h0A; in_last = 1'b1; grid_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0; grid_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || grid_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow sticky: err=%b gv=%b rdy=%b, need 1/0/1",
                     err, grid_valid, in_ready);
        end
        do_reset();
        @(negedge clk);
        check_idle("overflow_reset");
    endtask

    task automatic test_illegal_last();
        set_stim("@x", 1'b1);
        run_stream("illegal_last");
        n_cmp++;
        if (err !== 1'b1 || grid_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_last: err=%b gv=%b, need 1/0", err, grid_valid);
        end
        do_reset();
    endtask

    task automatic test_done_hold();
        set_stim("@.@.\n", 1'b1);
        run_stream("done_hold");
        in_valid = 1'b1; in_data = 8'h40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || grid_flat !== 16'h0005 || rows_loaded !== 3'd1 ||
                grid_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL done_hold c%0d: rdy=%b grid=%h rows=%0d gv=%b, need 0/0005/1/1",
                         i, in_ready, grid_flat, rows_loaded, grid_valid);
            end
        end
        grid_ack = 1'b1;
        @(posedge clk);
        #1;
        grid_ack = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("done_ack");
        set_stim("..@@\n@@@@\n", 1'b1);
        run_stream("second");
        n_cmp++;
        if (grid_flat !== 16'h00FC || rows_loaded !== 3'd2 ||
            paper_count !== 5'(exp_pc(6))) begin
            n_bad++;
            $display("FAIL second const: grid=%h rows=%0d pc=%0d, need 00fc/2/%0d",
                     grid_flat, rows_loaded, paper_count, exp_pc(6));
        end
        ack_check("second");
    endtask

    task automatic test_reset_midrow();
        set_stim("@@.@\n.@@.\n@.", 1'b0);
        run_stream("midrow");
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h40; in_last = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check_idle("midrow_reset");
        set_stim("@...\n", 1'b1);
        run_stream("fresh");
        n_cmp++;
        if (grid_flat !== 16'h0001 || rows_loaded !== 3'd1 ||
            paper_count !== 5'(exp_pc(1))) begin
            n_bad++;
            $display("FAIL fresh const: grid=%h rows=%0d pc=%0d, need 0001/1/%0d",
                     grid_flat, rows_loaded, paper_count, exp_pc(1));
        end
        ack_check("fresh");
    endtask

    task automatic test_random();
        int k;
        int len;
        logic [7:0] ch;
        for (int t = 0; t < 25; t++) begin
            stim.delete();
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) begin
                k = $urandom_range(0, 99);
                if (k < 35) ch = 8'h40;
                else if (k < 68) ch = 8'h2E;
                else if (k < 94) ch = 8'h0A;
                else if (k < 98) ch = 8'h0D;
                else ch = 8'($urandom_range(8'h61, 8'h7A));
                stim.push_back(ch);
            end
            stim_last = 1'($urandom_range(0, 1));
            run_stream($sformatf("rand%0d", t));
            if (m_done) ack_check($sformatf("rand%0d", t));
            else do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_example();
        test_last_partial();
        test_overflow();
        test_illegal_last();
        test_done_hold();
        test_reset_midrow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
